// File: rtl/mmio_ctrl.sv
// mmio_ctrl: CPU-facing MMIO window with a status register, a UART RX FIFO, a one-byte TX holding register and optional counters.
// Latency: reads are registered and data_out updates one cycle after re_in. RX backpressure comes from uart_rx_ready_out (!full); TX holds one byte until the handshake.
// Config: define MMIO_COUNTERS_EN to build the cycle and instruction counters at 0x10/0x14 and the clear register at 0x18.
module mmio_ctrl #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                RX_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              we_in,
  input  logic              re_in,
  output logic [DWIDTH-1:0] data_out,
  input  logic [7:0]        uart_rx_data_in,
  input  logic              uart_rx_valid_in,
  output logic              uart_rx_ready_out,
  output logic [7:0]        uart_tx_data_out,
  output logic              uart_tx_valid_out,
  input  logic              uart_tx_ready_in,
  input  logic              inst_valid_in
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [AWIDTH-1:0] A_STATUS = BASE_ADDR;
  localparam logic [AWIDTH-1:0] A_RXD    = BASE_ADDR + AWIDTH'(4);
  localparam logic [AWIDTH-1:0] A_TXD    = BASE_ADDR + AWIDTH'(8);
  localparam logic [AWIDTH-1:0] A_CYC    = BASE_ADDR + AWIDTH'(16);
  localparam logic [AWIDTH-1:0] A_INS    = BASE_ADDR + AWIDTH'(20);
  localparam logic [AWIDTH-1:0] A_CLR    = BASE_ADDR + AWIDTH'(24);

  logic [7:0]        rx_mem [RX_DEPTH];
  logic [PW-1:0]     rx_wr_ptr;
  logic [PW-1:0]     rx_rd_ptr;
  logic [CW-1:0]     rx_cnt;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_empty;
  logic              tx_full;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic [DWIDTH-1:0] status;
  logic [DWIDTH-1:0] rdata;
  logic [DWIDTH-1:0] cyc_rd;
  logic [DWIDTH-1:0] ins_rd;
  logic              unused_data;

  // Upper write-data bits are never stored; only the TX byte lane is used.
  assign unused_data = ^(data_in >> 8);

  assign rx_empty          = (rx_cnt == '0);
  assign uart_rx_ready_out = (rx_cnt != CW'(RX_DEPTH));
  assign rx_push           = uart_rx_valid_in && uart_rx_ready_out;
  assign rx_pop            = re_in && (addr_in == A_RXD) && !rx_empty;
  assign tx_wr             = we_in && (addr_in == A_TXD) && !tx_full;
  assign uart_tx_valid_out = tx_full;
  assign uart_tx_data_out  = tx_data;

  // Status word: TX empty, RX non-empty, RX occupancy; everything else reads 0.
  always_comb begin
    status          = '0;
    status[0]       = !tx_full;
    status[1]       = !rx_empty;
    status[2 +: CW] = rx_cnt;
  end

  // Read decode; unmapped and write-only offsets fall through to 0.
  always_comb begin
    rdata = '0;
    case (addr_in)
      A_STATUS: rdata = status;
      A_RXD:    rdata = rx_empty ? '0 : DWIDTH'(rx_mem[rx_rd_ptr]);
      A_CYC:    rdata = cyc_rd;
      A_INS:    rdata = ins_rd;
      default:  rdata = '0;
    endcase
  end

  // Registered read data, held while re_in is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     data_out <= '0;
    else if (re_in) data_out <= rdata;
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_cnt    <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // TX holding register: a write is taken only when empty, so a write on the handshake edge is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full <= 1'b0;
      tx_data <= 8'h00;
    end else if (tx_wr) begin
      tx_full <= 1'b1;
      tx_data <= data_in[7:0];
    end else if (tx_full && uart_tx_ready_in) begin
      tx_full <= 1'b0;
    end
  end

`ifdef MMIO_COUNTERS_EN
  logic [DWIDTH-1:0] cyc_cnt;
  logic [DWIDTH-1:0] ins_cnt;
  logic              cnt_clr;

  assign cnt_clr = we_in && (addr_in == A_CLR);
  assign cyc_rd  = cyc_cnt;
  assign ins_rd  = ins_cnt;

  // Free-running counters; a clear write wins over the increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + DWIDTH'(1);
      ins_cnt <= ins_cnt + DWIDTH'(inst_valid_in);
    end
  end
`else
  logic unused_cnt;

  assign cyc_rd     = '0;
  assign ins_rd     = '0;
  assign unused_cnt = inst_valid_in;
`endif

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter AWIDTH, default 32, address bus width.
REQ-002 Parameter DWIDTH, default 32, data bus and counter width.
REQ-003 Parameter BASE_ADDR, default 32'h8000_0000, base of the MMIO window.
REQ-004 Parameter RX_DEPTH, default 4, UART RX FIFO entries (power of two, >=2).
REQ-005 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addr_in  in  AWIDTH  CPU byte address.
- data_in  in  DWIDTH  CPU write data.
- we_in  in  1  write strobe.
- re_in  in  1  read strobe.
- data_out  out  DWIDTH  registered read data.
- uart_rx_data_in  in  8  received byte.
- uart_rx_valid_in  in  1  received byte valid.
- uart_rx_ready_out  out  1  FIFO can accept a byte.
- uart_tx_data_out  out  8  byte to transmit.
- uart_tx_valid_out  out  1  TX byte valid.
- uart_tx_ready_in  in  1  transmitter accepts byte.
- inst_valid_in  in  1  one instruction retired this cycle.

Function
REQ-006 Register map SHALL be, at offsets from BASE_ADDR: 0x00 status (RO), 0x04 RX data (RO, pops), 0x08 TX data (WO), 0x10 cycle counter (RO), 0x14 instruction counter (RO), 0x18 counter reset (WO).
REQ-007 Status SHALL be: bit0 = TX holding register empty, bit1 = RX FIFO non-empty, bits[2+:log2(RX_DEPTH)+1] = RX occupancy, all other bits 0.
REQ-008 Reads SHALL have one-cycle latency: data_out is loaded on the rising edge where re_in=1 and holds its value when re_in=0.
REQ-009 Reads of unmapped or write-only offsets SHALL return 0; writes to unmapped or read-only offsets SHALL be ignored.
REQ-010 uart_rx_ready_out SHALL equal !FIFO-full, combinationally; a byte is pushed on every edge with uart_rx_valid_in && uart_rx_ready_out.
REQ-011 A read of 0x04 on a non-empty FIFO SHALL return the head byte, zero-extended, and pop it on the same edge; on an empty FIFO it SHALL return 0 without popping.
REQ-012 A push and a pop on the same edge SHALL leave occupancy unchanged and preserve byte order; read/write pointers wrap modulo RX_DEPTH.
REQ-013 A write to 0x08 while the TX holding register is empty SHALL latch data_in[7:0] and assert uart_tx_valid_out from the next cycle.
REQ-014 A write to 0x08 while the TX holding register is full SHALL be dropped, including on the edge where the handshake completes.
REQ-015 uart_tx_valid_out and uart_tx_data_out SHALL stay stable until the edge with uart_tx_valid_out && uart_tx_ready_in, after which uart_tx_valid_out clears.
REQ-016 The cycle counter SHALL increment by 1 every edge, and the instruction counter SHALL increment by 1 on edges with inst_valid_in=1; both wrap modulo 2^DWIDTH.
REQ-017 A write of any data to 0x18 SHALL clear both counters to 0 on that edge, taking priority over any increment.
REQ-018 A read and a clear/increment on the same edge SHALL return the pre-edge value.
REQ-019 we_in and re_in asserted together SHALL be serviced independently, each per its own address decode.

Reset
REQ-020 While rst_n=0 the block SHALL asynchronously set:
- data_out = 0;
- both counters = 0;
- RX FIFO empty, pointers 0;
- TX holding register empty, uart_tx_valid_out = 0, uart_tx_data_out = 0.
REQ-021 Reset asserted mid-transfer SHALL discard FIFO contents and any pending TX byte, with no handshake completing.
REQ-022 uart_rx_ready_out SHALL read 1 during and immediately after reset.

Configuration
REQ-023 Macro MMIO_COUNTERS_EN defined: the counters and offsets 0x10/0x14/0x18 SHALL behave per REQ-016..018.
REQ-024 Macro MMIO_COUNTERS_EN undefined: no counter registers SHALL be instantiated, offsets 0x10/0x14 SHALL read 0, and 0x18 SHALL be ignored.

Verification
REQ-025 Bytes 0x41,0x42,0x43 pushed with re_in idle -> status bit1=1, occupancy=3; three reads of 0x04 -> data_out 0x41,0x42,0x43 one cycle after each read; a fourth read -> 0.
REQ-026 RX_DEPTH=4 with 5 bytes offered back-to-back -> uart_rx_ready_out=0 after the 4th push; 5th byte held off; one pop then accepts it; all 5 read in order.
REQ-027 Write 0x55 to 0x08 with uart_tx_ready_in=0 for 3 cycles -> valid held with data 0x55; second write 0xAA dropped; ready=1 -> one handshake, valid clears, status bit0=1.
REQ-028 After 100 cycles with inst_valid_in high on 40 of them -> reads of 0x10/0x14 return 100/40 plus read-edge offset; write 0x18 -> both read 0 on the next read; counter preset to 0xFFFFFFFF wraps to 0.
REQ-029 rst_n pulsed low asynchronously mid-cycle with FIFO at 2 entries and TX pending -> outputs zero immediately, status reads 0x1 after release.
REQ-030 Build without MMIO_COUNTERS_EN -> reads of 0x10/0x14 return 0 while UART behaviour per REQ-025..027 is unchanged.
